// File: rtl/trellis_io_pkg.sv
// Shared types and constants for the trellis_io pad bank.
// Optional capture register is enabled by defining TRELLIS_IO_IREG_EN.
package trellis_io_pkg;

  typedef enum logic [1:0] {
    DIR_BIDIR  = 2'd0,
    DIR_INPUT  = 2'd1,
    DIR_OUTPUT = 2'd2
  } dir_e;

  // Counter width; covers the supported TURNAROUND range 0..7.
  localparam int TA_W = 3;

endpackage

// File: rtl/trellis_io_turnaround.sv
// Turnaround counter and drive-enable generation for the pad bank.
// Drive is granted only after TURNAROUND edges with T low; T high releases at once.
module trellis_io_turnaround
  import trellis_io_pkg::*;
#(
  parameter dir_e DIR        = DIR_BIDIR,
  parameter int   TURNAROUND = 1
) (
  input  logic fifo_clk_i,
  input  logic reset_n_i,
  input  logic T,
  output logic drive_o
);

  localparam logic [TA_W-1:0] TA_LOAD = TA_W'(TURNAROUND);

  logic [TA_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt <= TA_LOAD;
    end else if (T) begin
      cnt <= TA_LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - TA_W'(1);
    end
  end

  // Gating with reset_n_i keeps the pads released for TURNAROUND=0 during reset.
  always_comb begin
    drive_o = 1'b0;
    case (DIR)
      DIR_BIDIR:  drive_o = reset_n_i & ~T & (cnt == '0);
      DIR_OUTPUT: drive_o = reset_n_i;
      default:    drive_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/trellis_io_bank.sv
// Bank of WIDTH bidirectional pad cells sharing one turnaround-guarded drive enable.
// Define TRELLIS_IO_IREG_EN to read O through a capture register (1-cycle latency).
module trellis_io_bank
  import trellis_io_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter dir_e DIR        = DIR_BIDIR,
  parameter int   TURNAROUND = 1
) (
  input  logic             fifo_clk_i,
  input  logic             reset_n_i,
  inout  wire  [WIDTH-1:0] B,
  input  logic             T,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             drive_o
);

  trellis_io_turnaround #(
    .DIR        (DIR),
    .TURNAROUND (TURNAROUND)
  ) u_turnaround (
    .fifo_clk_i (fifo_clk_i),
    .reset_n_i  (reset_n_i),
    .T          (T),
    .drive_o    (drive_o)
  );

  for (genvar k = 0; k < WIDTH; k++) begin : g_pad
    assign B[k] = drive_o ? I[k] : 1'bz;
  end

`ifdef TRELLIS_IO_IREG_EN
  logic [WIDTH-1:0] capture;

  // Holds the last externally driven value while the bank owns the bus.
  always_ff @(posedge fifo_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      capture <= '0;
    end else if (!drive_o) begin
      capture <= B;
    end
  end

  assign O = capture;
`else
  assign O = B;
`endif

endmodule

// File: tb/tb_trellis_io_bank.sv
// Directed bench for trellis_io_bank: four instances covering TURNAROUND=1/3,
// DIR_INPUT and DIR_OUTPUT; each pad bus has its own external driver.
module tb_trellis_io_bank;
  import trellis_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       t;
  logic [7:0] i_data;

  logic       ext1_en, ext3_en, extin_en, extout_en;
  logic [7:0] ext1_val, ext3_val, extin_val, extout_val;

  wire  [7:0] bus1, bus3, busin, busout;
  logic [7:0] o1, o3, oin, oout;
  logic       drive1, drive3, drivein, driveout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign bus1   = ext1_en   ? ext1_val   : 'z;
  assign bus3   = ext3_en   ? ext3_val   : 'z;
  assign busin  = extin_en  ? extin_val  : 'z;
  assign busout = extout_en ? extout_val : 'z;

  trellis_io_bank #(.WIDTH(8), .DIR(DIR_BIDIR), .TURNAROUND(1)) u_ta1 (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(bus1), .T(t), .I(i_data), .O(o1), .drive_o(drive1));

  trellis_io_bank #(.WIDTH(8), .DIR(DIR_BIDIR), .TURNAROUND(3)) u_ta3 (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(bus3), .T(t), .I(i_data), .O(o3), .drive_o(drive3));

  trellis_io_bank #(.WIDTH(8), .DIR(DIR_INPUT), .TURNAROUND(1)) u_in (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(busin), .T(t), .I(i_data), .O(oin), .drive_o(drivein));

  trellis_io_bank #(.WIDTH(8), .DIR(DIR_OUTPUT), .TURNAROUND(1)) u_out (
    .fifo_clk_i(clk), .reset_n_i(rst_n), .B(busout), .T(t), .I(i_data), .O(oout), .drive_o(driveout));

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    t     = 1'b0;
    i_data = 8'hA5;
    ext1_en = 1'b1;   ext1_val = 8'h5A;
    ext3_en = 1'b1;   ext3_val = 8'h5A;
    extin_en = 1'b1;  extin_val = 8'h5A;
    extout_en = 1'b1; extout_val = 8'h5A;

    // Reset: pads released, nothing driven.
    tick();
    tick();
    check("reset_drive1", {7'd0, drive1}, 8'h00);
    check("reset_bus1", bus1, 8'h5A);
    check("reset_drive3", {7'd0, drive3}, 8'h00);
    check("reset_drive_out", {7'd0, driveout}, 8'h00);
`ifdef TRELLIS_IO_IREG_EN
    check("reset_o1", o1, 8'h00);
`else
    check("reset_o1", o1, 8'h5A);
`endif

    // Release reset with T=0: TURNAROUND=1 drives after one edge.
    rst_n = 1'b1;
    ext1_en = 1'b0;
    ext3_en = 1'b0;
    extout_en = 1'b0;
    #1;
    check("rel_drive1_wait", {7'd0, drive1}, 8'h00);
    check("rel_drive_out", {7'd0, driveout}, 8'h01);
    check("rel_bus_out", busout, 8'hA5);
    tick();
    check("rel_drive1", {7'd0, drive1}, 8'h01);
    check("rel_bus1", bus1, 8'hA5);
    check("rel_drive3_e1", {7'd0, drive3}, 8'h00);
    tick();
    check("rel_drive3_e2", {7'd0, drive3}, 8'h00);
    tick();
    check("rel_drive3_e3", {7'd0, drive3}, 8'h01);
    check("rel_bus3", bus3, 8'hA5);

    // DIR_INPUT never drives.
    check("in_drive", {7'd0, drivein}, 8'h00);
    check("in_bus", busin, 8'h5A);
    check("in_o", oin, 8'h5A);

    // Read: T=1 releases in the same cycle, external data appears on O.
    t = 1'b1;
    ext1_en = 1'b1; ext1_val = 8'h3C;
    ext3_en = 1'b1; ext3_val = 8'h3C;
    #1;
    check("read_drive1", {7'd0, drive1}, 8'h00);
    check("read_bus1", bus1, 8'h3C);
    check("read_drive3", {7'd0, drive3}, 8'h00);
    check("read_bus3", bus3, 8'h3C);
`ifndef TRELLIS_IO_IREG_EN
    check("read_o1_comb", o1, 8'h3C);
`endif
    tick();
    check("read_o1_edge", o1, 8'h3C);
    check("read_drive1_edge", {7'd0, drive1}, 8'h00);

    // DIR_OUTPUT ignores T.
    i_data = 8'h81;
    #1;
    check("out_bus", busout, 8'h81);
    check("out_drive", {7'd0, driveout}, 8'h01);

    // Turnaround: T falls, TURNAROUND=3 waits three edges.
    t = 1'b0;
    ext1_en = 1'b0;
    ext3_en = 1'b0;
    #1;
    check("ta_e0", {7'd0, drive3}, 8'h00);
    tick();
    check("ta1_drive", {7'd0, drive1}, 8'h01);
    check("ta1_bus", bus1, 8'h81);
    check("ta_e1", {7'd0, drive3}, 8'h00);
    tick();
    check("ta_e2", {7'd0, drive3}, 8'h00);
    tick();
    check("ta_e3", {7'd0, drive3}, 8'h01);
    check("ta_bus3", bus3, 8'h81);
`ifndef TRELLIS_IO_IREG_EN
    check("ta_loopback", o3, 8'h81);
`endif

    // Zero-latency release, then mid-turnaround abort restarts the count.
    t = 1'b1;
    ext3_en = 1'b1; ext3_val = 8'hC3;
    #1;
    check("ab_release", {7'd0, drive3}, 8'h00);
    check("ab_release_bus", bus3, 8'hC3);
    tick();
    t = 1'b0;
    ext3_en = 1'b0;
    tick();
    tick();
    check("ab_first_e2", {7'd0, drive3}, 8'h00);
    t = 1'b1;
    #1;
    check("ab_pulse", {7'd0, drive3}, 8'h00);
    tick();
    t = 1'b0;
    tick();
    check("ab_e1", {7'd0, drive3}, 8'h00);
    tick();
    check("ab_e2", {7'd0, drive3}, 8'h00);
    tick();
    check("ab_e3", {7'd0, drive3}, 8'h01);

    // DIR_INPUT with T=0 and I=FF still never drives.
    i_data = 8'hFF;
    #1;
    check("in_ff_drive", {7'd0, drivein}, 8'h00);
    check("in_ff_bus", busin, 8'h5A);
    tick();
    check("in_ff_bus_edge", busin, 8'h5A);

    // Async reset between edges releases immediately.
    i_data = 8'h55;
    tick();
    check("ar_bus1_driven", bus1, 8'h55);
    check("ar_bus3_driven", bus3, 8'h55);
    #2;
    rst_n = 1'b0;
    ext1_en = 1'b1;   ext1_val = 8'hAA;
    ext3_en = 1'b1;   ext3_val = 8'hAA;
    extout_en = 1'b1; extout_val = 8'hAA;
    #1;
    check("ar_drive1", {7'd0, drive1}, 8'h00);
    check("ar_bus1", bus1, 8'hAA);
    check("ar_drive3", {7'd0, drive3}, 8'h00);
    check("ar_drive_out", {7'd0, driveout}, 8'h00);
    check("ar_bus_out", busout, 8'hAA);
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
